// File: rtl/mbyte_alu_seq_if.sv
// Request/response handshake bundle for the multi-byte ALU sequencer.
// slave = sequencer side, master = requester/consumer side.
interface mbyte_alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_len;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_zero;

  modport slave (
    input  req_valid, req_op, req_len, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  modport master (
    output req_valid, req_op, req_len, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/mbyte_alu_seq.sv
// Sequences 1..4-byte ADD/SUB/SHL/SHR through an external byte ALU, one byte per cycle.
// Response valid N cycles after accept; result held in DONE until rsp_ready, no accept until then.
module mbyte_alu_seq (
  input  logic                 clk,
  input  logic                 reset,
  mbyte_alu_seq_if.slave       bus,
  output logic [2:0]           alu_cmd,
  output logic [7:0]           alu_inA,
  output logic [7:0]           alu_inB,
  output logic                 alu_sc_i,
  input  logic [7:0]           alu_rslt,
  input  logic                 alu_sc_o,
  input  logic                 alu_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_SHL = 2'd2;
  localparam logic [1:0] OP_SHR = 2'd3;

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SHL = 3'b001;
  localparam logic [2:0] CMD_SHR = 3'b010;

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [1:0]  len_q;
  logic [1:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        carry_q;
  logic        zero_q;

  logic [1:0]  idx;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;

  // SHR walks from the top byte down so the shifted-out bit chains into the next lower byte.
  always_comb begin
    idx    = (op_q == OP_SHR) ? (len_q - cnt_q) : cnt_q;
    a_byte = a_q[{idx, 3'b000} +: 8];
    b_byte = b_q[{idx, 3'b000} +: 8];
  end

  always_comb begin
    alu_cmd  = CMD_ADD;
    alu_inA  = 8'h00;
    alu_inB  = 8'h00;
    alu_sc_i = 1'b0;
    if (state == EXEC) begin
      alu_inA  = a_byte;
      alu_sc_i = (cnt_q == 2'd0) ? (op_q == OP_SUB) : carry_q;
      case (op_q)
        OP_ADD: begin
          alu_cmd = CMD_ADD;
          alu_inB = b_byte;
        end
        OP_SUB: begin
          alu_cmd = CMD_ADD;
          alu_inB = ~b_byte;
        end
        OP_SHL:  alu_cmd = CMD_SHL;
        default: alu_cmd = CMD_SHR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= 2'd0;
      len_q   <= 2'd0;
      cnt_q   <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            len_q   <= bus.req_len;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            cnt_q   <= 2'd0;
            res_q   <= 32'd0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_q[{idx, 3'b000} +: 8] <= alu_rslt;
          carry_q <= alu_sc_o;
          zero_q  <= zero_q & alu_zero;
          if (cnt_q == len_q) begin
            state <= DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = res_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_zero  = zero_q;

endmodule

// File: tb/tb_mbyte_alu_seq.sv
// Bench for mbyte_alu_seq: behavioural byte ALU, vector table, scoreboard queue, abort/backpressure sequences.
module tb_mbyte_alu_seq;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  len;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_c;
    logic        exp_z;
    int          hold;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mbyte_alu_seq_if bus ();

  logic [2:0] alu_cmd;
  logic [7:0] alu_inA, alu_inB, alu_rslt;
  logic       alu_sc_i, alu_sc_o, alu_zero;

  mbyte_alu_seq dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_cmd  (alu_cmd),
    .alu_inA  (alu_inA),
    .alu_inB  (alu_inB),
    .alu_sc_i (alu_sc_i),
    .alu_rslt (alu_rslt),
    .alu_sc_o (alu_sc_o),
    .alu_zero (alu_zero)
  );

  // Byte ALU: 000 add with carry-in, 001 shift left (sc_i into bit 0), 010 shift right (sc_i into bit 7).
  always_comb begin
    alu_rslt = 8'h00;
    alu_sc_o = 1'b0;
    case (alu_cmd)
      3'b000: {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'h00, alu_sc_i};
      3'b001: begin
        alu_rslt = {alu_inA[6:0], alu_sc_i};
        alu_sc_o = alu_inA[7];
      end
      3'b010: begin
        alu_rslt = {alu_sc_i, alu_inA[7:1]};
        alu_sc_o = alu_inA[0];
      end
      default: alu_rslt = 8'h00;
    endcase
    alu_zero = (alu_rslt == 8'h00);
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int bad_cmd = 0;
  vec_t exp_q[$];
  vec_t vecs[12];

  always @(negedge clk) begin
    if (alu_cmd == 3'b011 || alu_cmd == 3'b100) bad_cmd++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void model(input logic [1:0] op, input logic [1:0] len,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic c);
    int nb;
    logic [32:0] m, s;
    nb = (int'(len) + 1) * 8;
    m  = (33'd1 << nb) - 33'd1;
    case (op)
      2'd0:    s = ({1'b0, a} & m) + ({1'b0, b} & m);
      2'd1:    s = ({1'b0, a} & m) + ({1'b0, ~b} & m) + 33'd1;
      2'd2:    s = ({1'b0, a} & m) << 1;
      default: s = ({1'b0, a} & m) >> 1;
    endcase
    d = s[31:0] & m[31:0];
    c = (op == 2'd3) ? a[0] : s[nb];
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int w, lat;
    logic [7:0]  first_ina, exp_first;
    logic [31:0] snap_d;
    logic        snap_c, snap_z, stable_ok;
    vec_t        got;
    @(negedge clk);
    bus.req_op    = v.op;
    bus.req_len   = v.len;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    exp_q.push_back(v);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_len   = 2'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    @(negedge clk);
    first_ina = alu_inA;
    exp_first = (v.op == 2'd3) ? v.a[{v.len, 3'b000} +: 8] : v.a[7:0];
    check({tag, "_first_byte"}, {24'd0, first_ina}, {24'd0, exp_first});
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, int'(v.len) + 1);
    check({tag, "_alu_idle"}, {17'd0, alu_cmd, alu_inA, alu_inB, alu_sc_i}, 32'd0);
    snap_d = bus.rsp_data;
    snap_c = bus.rsp_carry;
    snap_z = bus.rsp_zero;
    for (int h = 0; h < v.hold; h++) begin
      bus.req_valid = 1'b1;
      @(negedge clk);
      stable_ok = (bus.rsp_data === snap_d) && (bus.rsp_carry === snap_c) &&
                  (bus.rsp_zero === snap_z) && (bus.rsp_valid === 1'b1) && (bus.req_ready === 1'b0);
      check({tag, "_hold_stable"}, {31'd0, stable_ok}, 32'd1);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    snap_d = bus.rsp_data;
    snap_c = bus.rsp_carry;
    snap_z = bus.rsp_zero;
    @(posedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check({tag, "_data"},  snap_d, got.exp_d);
      check({tag, "_carry"}, {31'd0, snap_c}, {31'd0, got.exp_c});
      check({tag, "_zero"},  {31'd0, snap_z}, {31'd0, got.exp_z});
    end
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_reaccept"}, {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        v;
    logic [31:0] d;
    logic        c;
    logic        no_rsp;

    vecs[0]  = '{2'd0, 2'd3, 32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0, 0};
    vecs[1]  = '{2'd1, 2'd1, 32'h00000005, 32'h00000006, 32'h0000FFFF, 1'b0, 1'b0, 5};
    vecs[2]  = '{2'd1, 2'd1, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b1, 0};
    vecs[3]  = '{2'd2, 2'd0, 32'h00000081, 32'h00000000, 32'h00000002, 1'b1, 1'b0, 0};
    vecs[4]  = '{2'd3, 2'd1, 32'h00000101, 32'h00000000, 32'h00000080, 1'b1, 1'b0, 1};
    vecs[5]  = '{2'd0, 2'd1, 32'hFFFF00FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 0};
    vecs[6]  = '{2'd0, 2'd0, 32'h000000FF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 0};
    vecs[7]  = '{2'd3, 2'd3, 32'h80000001, 32'h00000000, 32'h40000000, 1'b1, 1'b0, 2};
    vecs[8]  = '{2'd2, 2'd3, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 0};
    vecs[9]  = '{2'd1, 2'd3, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 0};
    vecs[10] = '{2'd0, 2'd2, 32'h12345678, 32'hAB000001, 32'h00345679, 1'b0, 1'b0, 0};
    vecs[11] = '{2'd3, 2'd0, 32'hFFFFFF02, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 0};

    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_len   = 2'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp", {bus.rsp_data}, 32'd0);
    check("reset_flags", {28'd0, bus.req_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_zero}, 32'h8);
    check("reset_alu", {17'd0, alu_cmd, alu_inA, alu_inB, alu_sc_i}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      v.op   = 2'($urandom_range(0, 3));
      v.len  = 2'($urandom_range(0, 3));
      v.a    = $urandom;
      v.b    = $urandom;
      v.hold = $urandom_range(0, 3);
      model(v.op, v.len, v.a, v.b, d, c);
      v.exp_d = d;
      v.exp_c = c;
      v.exp_z = (d == 32'd0);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Abort an N=4 ADD while its second byte is being issued.
    @(negedge clk);
    bus.req_op    = 2'd0;
    bus.req_len   = 2'd3;
    bus.req_a     = 32'h00FFFFFF;
    bus.req_b     = 32'h00000001;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_rsp_data", bus.rsp_data, 32'd0);
    check("abort_flags", {28'd0, bus.req_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_zero}, 32'h8);
    check("abort_alu", {17'd0, alu_cmd, alu_inA, alu_inB, alu_sc_i}, 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    no_rsp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) no_rsp = 1'b0;
    end
    check("abort_no_rsp", {31'd0, no_rsp}, 32'd1);
    run_txn(vecs[0], "after_abort");

    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("no_illegal_cmd", bad_cmd, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mbyte_alu_seq.md
MBYTE_ALU_SEQ -- requirements
Module: mbyte_alu_seq

Interface
REQ-001 Parameters: none; maximum operand width is fixed at 4 bytes (32 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low asserts, release synchronous to clk.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_op  input  2  operation: 00 ADD, 01 SUB, 10 SHL, 11 SHR.
REQ-007 req_len  input  2  operand length in bytes minus 1 (N = req_len+1, 1..4).
REQ-008 req_a, req_b  input  32  operands; bytes above N-1 ignored.
REQ-009 alu_cmd  output  3  command to byte ALU (000 add, 001 left shift, 010 right shift).
REQ-010 alu_inA, alu_inB  output  8  byte operands to ALU.
REQ-011 alu_sc_i  output  1  carry/shift-in to ALU.
REQ-012 alu_rslt  input  8;  alu_sc_o  input  1;  alu_zero  input  1  combinational ALU results, same cycle.
REQ-013 rsp_valid  output  1;  rsp_ready  input  1  response handshake.
REQ-014 rsp_data  output  32;  rsp_carry  output  1;  rsp_zero  output  1  result, final carry, all-zero flag.

Function
REQ-015 FSM states IDLE, EXEC, DONE; IDLE->EXEC on req_valid&&req_ready; EXEC->DONE after byte N-1 captured; DONE->IDLE on rsp_valid&&rsp_ready.
REQ-016 req_ready=1 only in IDLE; rsp_valid=1 only in DONE; no same-cycle accept in DONE.
REQ-017 On accept, latch req_op, req_len, req_a, req_b; byte counter cleared; later input changes have no effect.
REQ-018 EXEC issues exactly one byte per cycle; each clock edge captures alu_rslt into the current result byte and alu_sc_o into the carry register.
REQ-019 ADD: alu_cmd=000, bytes LSB first, alu_inA/alu_inB = operand bytes, alu_sc_i=0 for byte 0, then previous alu_sc_o.
REQ-020 SUB: alu_cmd=000, alu_inB = bitwise inverse of B byte, alu_sc_i=1 for byte 0, then previous alu_sc_o; rsp_carry=1 means no borrow.
REQ-021 SHL: alu_cmd=001, A bytes LSB first, alu_inB=0, alu_sc_i=0 for byte 0, then chained; rsp_carry = bit shifted out of A bit 8N-1.
REQ-022 SHR: alu_cmd=010, A bytes MSB first (byte N-1 down to 0), alu_inB=0, alu_sc_i=0 for first byte, then chained; rsp_carry = bit shifted out of A bit 0.
REQ-023 rsp_data bytes >= N are 0; rsp_zero = AND of alu_zero over all N issued bytes.
REQ-024 Latency: rsp_valid rises exactly N cycles after the accepting edge; throughput one request per N+2 cycles minimum.
REQ-025 In DONE, rsp_data/rsp_carry/rsp_zero held stable until handshake, regardless of rsp_ready duration.
REQ-026 Outside EXEC: alu_cmd=000, alu_inA=0, alu_inB=0, alu_sc_i=0.
REQ-027 ALU NAND/SUB commands (011, 100) are never issued.

Reset
REQ-028 reset low forces IDLE immediately: req_ready=1 (while reset high afterwards), rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, ALU outputs per REQ-026, counter and carry cleared.
REQ-029 Reset during EXEC or DONE aborts the operation; no response produced for it.

Verification
REQ-030 ADD N=4, A=0x00FFFFFF, B=0x00000001 -> rsp_data=0x01000000, carry 0, zero 0, rsp_valid 4 cycles after accept.
REQ-031 SUB N=2, A=0x0005, B=0x0006 -> 0x0000FFFF, carry 0; A=B=0x1234 -> 0x00000000, carry 1, zero 1.
REQ-032 SHL N=1, A=0x81 -> 0x00000002, carry 1; SHR N=2, A=0x0101 -> 0x00000080, carry 1, first issued byte 0x01 (MSB).
REQ-033 ADD N=2, A=0xFFFF00FF, B=0x00000001 -> 0x00000100, carry 0 (upper bytes ignored).
REQ-034 rsp_ready low 5 cycles in DONE -> outputs stable, req_ready 0, req_valid ignored; accept resumes the cycle after handshake.
REQ-035 reset low during second EXEC byte of N=4 ADD -> all outputs reset values at once, no rsp_valid; following request completes correctly.
